// File: rtl/crc_stream_engine_if.sv
// Stream bundle for crc_stream_engine: beat input handshake
// and held result output handshake.
interface crc_stream_engine_if #(
  parameter int CRC_W  = 32,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  crc_out;
  logic [15:0]       frame_beats;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, crc_out, frame_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, crc_out, frame_beats
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Frame-oriented generic CRC engine, DATA_W bits per beat.
// Optional residue check of received codewords: CRC_CHECK_EN.
module crc_stream_engine #(
  parameter int               CRC_W       = 32,
  parameter int               DATA_W      = 8,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(32'h04C11DB7),
  parameter logic [CRC_W-1:0] INIT        = '1,
  parameter logic [CRC_W-1:0] XOR_OUT     = '1,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0
`ifdef CRC_CHECK_EN
  ,
  parameter logic [CRC_W-1:0] RESIDUE     = CRC_W'(32'hC704DD7B)
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  crc_stream_engine_if.slave bus
`ifdef CRC_CHECK_EN
  ,
  output logic crc_match
`endif
);

  typedef enum logic {ACCUM, DONE} state_e;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_out_q;
  logic [15:0]      beats_q;
  logic [CRC_W-1:0] crc_nxt;
  logic [CRC_W-1:0] crc_fin;
  logic [15:0]      cnt_inc;
  logic             accept;
  logic             load;

  function automatic logic [CRC_W-1:0] fold(
    input logic [CRC_W-1:0]  r,
    input logic [DATA_W-1:0] d
  );
    logic [CRC_W-1:0] c;
    logic             fb;
    c = r;
    for (int i = 0; i < DATA_W; i++) begin
      fb = c[CRC_W-1] ^ (REFLECT_IN ? d[i] : d[DATA_W-1-i]);
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev(
    input logic [CRC_W-1:0] r
  );
    logic [CRC_W-1:0] o;
    for (int i = 0; i < CRC_W; i++)
      o[i] = r[CRC_W-1-i];
    return o;
  endfunction

  assign bus.in_ready = !rst &&
    (state_q == ACCUM || bus.out_ready);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.crc_out     = crc_out_q;
  assign bus.frame_beats = beats_q;

  assign accept = bus.in_valid && bus.in_ready && !abort;
  assign crc_nxt = fold(crc_q, bus.in_data);
  assign crc_fin = (REFLECT_OUT ? bitrev(crc_nxt) : crc_nxt)
                   ^ XOR_OUT;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q
                                       : cnt_q + 16'd1;

  // A last beat taken while DONE replaces the held result.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (state_q == DONE && bus.out_ready)
      state_d = ACCUM;
    unique case (1'b1)
      abort: begin
        state_d = ACCUM;
        crc_d   = INIT;
        cnt_d   = '0;
      end
      accept && bus.in_last: begin
        state_d = DONE;
        crc_d   = INIT;
        cnt_d   = '0;
        load    = 1'b1;
      end
      accept && !bus.in_last: begin
        crc_d = crc_nxt;
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      crc_q     <= INIT;
      cnt_q     <= '0;
      crc_out_q <= '0;
      beats_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      if (load) begin
        crc_out_q <= crc_fin;
        beats_q   <= cnt_inc;
      end
    end
  end

`ifdef CRC_CHECK_EN
  logic match_q;

  assign crc_match = match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match_q <= 1'b0;
    else if (abort)
      match_q <= 1'b0;
    else if (load)
      match_q <= (crc_nxt == RESIDUE);
  end
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: three parameter sets
// driven in lockstep, checked against a long-division CRC model.
module tb_crc_stream_engine;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] CHK  = 32'hFC891918;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [15:0] nb;
    logic        m;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t res_q[$];
  bq_t  msg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_stream_engine_if #(.CRC_W(32), .DATA_W(8)) b0 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(8)) b1 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(8)) b2 ();

  assign b0.in_valid = in_valid;
  assign b0.in_data  = in_data;
  assign b0.in_last  = in_last;
  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;
  assign b1.in_data  = in_data;
  assign b1.in_last  = in_last;
  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;
  assign b2.in_data  = in_data;
  assign b2.in_last  = in_last;
  assign b2.out_ready = out_ready;

`ifdef CRC_CHECK_EN
  logic m0, m1, m2;
`endif

  crc_stream_engine u0 (
    .clk(clk), .rst(rst), .abort(abort), .bus(b0)
`ifdef CRC_CHECK_EN
    , .crc_match(m0)
`endif
  );

  crc_stream_engine #(.XOR_OUT(32'h0)) u1 (
    .clk(clk), .rst(rst), .abort(abort), .bus(b1)
`ifdef CRC_CHECK_EN
    , .crc_match(m1)
`endif
  );

  crc_stream_engine #(.REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u2 (
    .clk(clk), .rst(rst), .abort(abort), .bus(b2)
`ifdef CRC_CHECK_EN
    , .crc_match(m2)
`endif
  );

  // Result capture: handshake sampled mid-cycle.
  always @(negedge clk) begin
    res_t r;
    if (!rst && b0.out_valid && out_ready) begin
      r.c0 = b0.crc_out;
      r.c1 = b1.crc_out;
      r.c2 = b2.crc_out;
      r.nb = b0.frame_beats;
`ifdef CRC_CHECK_EN
      r.m = m0;
`else
      r.m = 1'b0;
`endif
      res_q.push_back(r);
    end
  end

  // Register remainder by polynomial long division of M*x^32 + INIT*x^n.
  function automatic logic [31:0] model_raw(input bq_t m, input bit refl);
    bit          a[$];
    logic [31:0] p;
    logic [31:0] r;
    int          n;
    p = POLY;
    foreach (m[i])
      for (int k = 0; k < 8; k++)
        a.push_back(refl ? m[i][k] : m[i][7-k]);
    n = a.size();
    for (int k = 0; k < 32; k++) a.push_back(1'b0);
    for (int k = 0; k < 32; k++) a[k] = a[k] ^ 1'b1;
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 1; j <= 32; j++) a[i+j] = a[i+j] ^ p[32-j];
    for (int j = 0; j < 32; j++) r[31-j] = a[n+j];
    return r;
  endfunction

  function automatic logic [31:0] model_crc(input bq_t m, input bit refl,
                                            input logic [31:0] xo);
    logic [31:0] raw;
    logic [31:0] o;
    raw = model_raw(m, refl);
    for (int i = 0; i < 32; i++) o[i] = refl ? raw[31-i] : raw[i];
    return o ^ xo;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bq_t m, input int gap_max, input bit with_last);
    bit acc;
    int guard;
    for (int i = 0; i < m.size(); i++) begin
      if (gap_max > 0)
        repeat ($urandom_range(0, gap_max)) begin
          in_valid = 1'b0;
          tick();
        end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = with_last && (i == m.size() - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = b0.in_ready;
        tick();
        guard++;
      end while (!acc && guard < 300);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL send_timeout beat %0d: in_ready=%b required 1", i, acc);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.crc_out !== 32'h0 ||
        b0.frame_beats !== 16'h0 || b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b crc=%h nb=%0d ir=%b required 0 0 0 0",
               b0.out_valid, b0.crc_out, b0.frame_beats, b0.in_ready);
    end
`ifdef CRC_CHECK_EN
    checks++;
    if (m0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_match: %b required 0", m0);
    end
`endif
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (b0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: %b required 1", b0.in_ready);
    end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    res_q.delete();
    send_frame(msg, 0, 1'b1);
    checks++;
    if (b0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b required 1", b0.out_valid);
    end
    checks++;
    if (b0.crc_out !== CHK) begin
      errors++;
      $display("FAIL bzip2: %h required %h", b0.crc_out, CHK);
    end
    checks++;
    if (b1.crc_out !== 32'h0376E6E7) begin
      errors++;
      $display("FAIL mpeg2: %h required 0376e6e7", b1.crc_out);
    end
    checks++;
    if (b2.crc_out !== 32'hCBF43926) begin
      errors++;
      $display("FAIL iso_hdlc: %h required cbf43926", b2.crc_out);
    end
    checks++;
    if (b0.frame_beats !== 16'd9) begin
      errors++;
      $display("FAIL beats: %0d required 9", b0.frame_beats);
    end
    tick();
    checks++;
    if (b0.out_valid !== 1'b0 || res_q.size() != 1) begin
      errors++;
      $display("FAIL release: ov=%b results=%0d required 0 1",
               b0.out_valid, res_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    out_ready = 1'b0;
    res_q.delete();
    fork
      begin
        send_frame(msg, 0, 1'b1);
        send_frame(msg, 0, 1'b1);
      end
      begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!b0.out_valid && guard < 50);
        repeat (5) begin
          checks++;
          if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0 ||
              b0.crc_out !== CHK) begin
            errors++;
            $display("FAIL stall_hold: ov=%b ir=%b crc=%h required 1 0 %h",
                     b0.out_valid, b0.in_ready, b0.crc_out, CHK);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    tick();
    tick();
    checks++;
    if (res_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d results required 2", res_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (res_q[i].c0 !== CHK || res_q[i].nb !== 16'd9) begin
          errors++;
          $display("FAIL b2b_result %0d: crc=%h nb=%0d required %h 9",
                   i, res_q[i].c0, res_q[i].nb, CHK);
        end
      end
    end
  endtask

  task automatic test_throughput();
    int c_start;
    out_ready = 1'b1;
    res_q.delete();
    c_start = cyc;
    send_frame(msg, 0, 1'b1);
    send_frame(msg, 0, 1'b1);
    checks++;
    if (cyc - c_start != 18) begin
      errors++;
      $display("FAIL throughput: %0d cycles required 18", cyc - c_start);
    end
    tick();
    checks++;
    if (res_q.size() != 2) begin
      errors++;
      $display("FAIL throughput_results: %0d required 2", res_q.size());
    end
  endtask

  task automatic test_abort();
    bq_t part;
    for (int i = 0; i < 4; i++) part.push_back(8'h41 + 8'(i));
    out_ready = 1'b1;
    res_q.delete();
    send_frame(part, 0, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_last  = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: out_valid=%b required 0", b0.out_valid);
    end
    send_frame(msg, 0, 1'b1);
    tick();
    checks++;
    if (res_q.size() != 1) begin
      errors++;
      $display("FAIL abort_count: %0d results required 1", res_q.size());
    end else begin
      checks++;
      if (res_q[0].c0 !== CHK || res_q[0].nb !== 16'd9) begin
        errors++;
        $display("FAIL abort_result: crc=%h nb=%0d required %h 9",
                 res_q[0].c0, res_q[0].nb, CHK);
      end
    end
    out_ready = 1'b0;
    send_frame(part, 0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: ov=%b ir=%b required 0 1",
               b0.out_valid, b0.in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_rst_mid();
    bq_t part;
    for (int i = 0; i < 5; i++) part.push_back(8'h31 + 8'(i));
    out_ready = 1'b1;
    send_frame(msg, 0, 1'b1);
    send_frame(part, 0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.crc_out !== 32'h0 ||
        b0.frame_beats !== 16'h0 || b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: ov=%b crc=%h nb=%0d ir=%b required 0 0 0 0",
               b0.out_valid, b0.crc_out, b0.frame_beats, b0.in_ready);
    end
    tick();
    rst = 1'b0;
    res_q.delete();
    send_frame(msg, 0, 1'b1);
    checks++;
    if (b0.crc_out !== CHK || b2.crc_out !== 32'hCBF43926 ||
        b0.frame_beats !== 16'd9) begin
      errors++;
      $display("FAIL rst_recover: crc=%h crc2=%h nb=%0d required %h cbf43926 9",
               b0.crc_out, b2.crc_out, b0.frame_beats, CHK);
    end
    tick();
  endtask

  task automatic test_random();
    res_t exp_q[$];
    res_t e;
    bq_t  m;
    bit   done;
    int   guard;
    res_q.delete();
    done = 1'b0;
    fork
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        for (int f = 0; f < 30; f++) begin
          m.delete();
          repeat ($urandom_range(1, 12)) m.push_back(8'($urandom));
          e.c0 = model_crc(m, 1'b0, 32'hFFFFFFFF);
          e.c1 = model_crc(m, 1'b0, 32'h0);
          e.c2 = model_crc(m, 1'b1, 32'hFFFFFFFF);
          e.nb = 16'(m.size());
          e.m  = 1'b0;
          exp_q.push_back(e);
          send_frame(m, (f % 3 == 0) ? 0 : 2, 1'b1);
        end
        done = 1'b1;
      end
    join
    guard = 0;
    while (res_q.size() < exp_q.size() && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (res_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: %0d results required %0d",
               res_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (res_q[i].c0 !== exp_q[i].c0 || res_q[i].c1 !== exp_q[i].c1 ||
            res_q[i].c2 !== exp_q[i].c2 || res_q[i].nb !== exp_q[i].nb) begin
          errors++;
          $display("FAIL random_frame %0d: %h %h %h %0d required %h %h %h %0d",
                   i, res_q[i].c0, res_q[i].c1, res_q[i].c2, res_q[i].nb,
                   exp_q[i].c0, exp_q[i].c1, exp_q[i].c2, exp_q[i].nb);
        end
      end
    end
    tick();
  endtask

`ifdef CRC_CHECK_EN
  task automatic test_crc_check();
    bq_t cw;
    bq_t bad;
    logic exp_m;
    int   pos;
    cw = msg;
    cw.push_back(8'hFC);
    cw.push_back(8'h89);
    cw.push_back(8'h19);
    cw.push_back(8'h18);
    out_ready = 1'b1;
    send_frame(cw, 0, 1'b1);
    exp_m = (model_raw(cw, 1'b0) == 32'hC704DD7B);
    checks++;
    if (m0 !== 1'b1 || exp_m !== 1'b1) begin
      errors++;
      $display("FAIL match_good: %b model %b required 1", m0, exp_m);
    end
    bad = cw;
    pos = $urandom_range(0, bad.size() - 1);
    bad[pos] = bad[pos] ^ (8'h01 << $urandom_range(0, 7));
    send_frame(bad, 0, 1'b1);
    checks++;
    if (m0 !== 1'b0) begin
      errors++;
      $display("FAIL match_bad: %b required 0", m0);
    end
    out_ready = 1'b0;
    send_frame(cw, 0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (m0 !== 1'b0) begin
      errors++;
      $display("FAIL match_abort: %b required 0", m0);
    end
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
    test_reset();
    test_vectors();
    test_back_to_back();
    test_throughput();
    test_abort();
    test_rst_mid();
    test_random();
`ifdef CRC_CHECK_EN
    test_crc_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, frame-oriented CRC engine that folds DATA_W message bits per clock into a CRC_W-bit LFSR, using a generic polynomial, init value, bit reflection and final XOR. It sits on a valid/ready byte/word stream: it accumulates a frame, presents the finished CRC on a held output handshake, and re-arms itself for the next frame without software intervention. Defaults produce CRC-32/BZIP2 on a byte stream.

## Interface
- CRC_W, 32, CRC register width (8..64)
- DATA_W, 8, bits consumed per accepted beat (1..64)
- POLY, 32'h04C11DB7, generator polynomial, implicit x^CRC_W term, CRC_W bits
- INIT, all ones, register value at frame start
- XOR_OUT, all ones, XOR applied to the result
- REFLECT_IN, 0, 1 = process each beat LSB first
- REFLECT_OUT, 0, 1 = bit-reverse the register before XOR_OUT
- RESIDUE, 32'hC704DD7B, expected raw register after a good codeword (CRC_CHECK_EN only)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  engine accepts beat
- in_data  in  DATA_W  message bits
- in_last  in  1  beat is final beat of frame
- abort  in  1  synchronous frame discard
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- crc_out  out  CRC_W  finished CRC
- frame_beats  out  16  beats in reported frame, saturates at 16'hFFFF
- crc_match  out  1  raw register == RESIDUE (CRC_CHECK_EN only)

## Operation
- States: ACCUM (collecting), DONE (result held). Reset: ACCUM, register = INIT, out_valid = 0, crc_out = 0, frame_beats = 0, crc_match = 0, beat counter = 0.
- in_ready = (state == ACCUM) || out_ready; 0 while rst asserted.
- Beat accepted when in_valid && in_ready. Per beat, DATA_W serial steps unrolled combinationally: bit d taken from in_data MSB downward (LSB upward if REFLECT_IN); fb = reg[CRC_W-1] ^ d; reg = (reg << 1) ^ (fb ? POLY : 0).
- Beat counter increments per accepted beat, saturating.
- Accepted beat with in_last: next cycle crc_out = (REFLECT_OUT ? bitrev(reg_new) : reg_new) ^ XOR_OUT, frame_beats = counter+1 (sat), out_valid = 1, state DONE; register and counter reload INIT / 0.
- DONE: crc_out, frame_beats, crc_match stable until out_valid && out_ready; then out_valid = 0, state ACCUM unless a new in_last beat is accepted same cycle (stays DONE with new result).
- A beat accepted in DONE (out_ready high) starts the next frame from INIT; no bubble between frames.
- abort (highest priority, any state): register = INIT, counter = 0, out_valid = 0, state ACCUM; any beat presented that cycle is dropped, in_ready still asserted as defined but the beat is discarded.
- Every frame has at least one beat; there is no empty frame.

## Timing
- Accept-to-result latency: 1 cycle after the last beat's handshake.
- Throughput: DATA_W bits/cycle sustained, including across frame boundaries when out_ready is held high.
- Single-beat frame: out_valid the cycle after acceptance.
- Mid-frame rst: all state to reset values immediately; partial frame lost.
- Output unchanged while out_valid && !out_ready (no overwrite; in_ready low blocks input).

## Configuration
- CRC_CHECK_EN defined: RESIDUE parameter and crc_match port exist; crc_match registered with crc_out, = (raw register after last beat == RESIDUE), used when the frame includes its appended CRC. Reset 0; cleared by abort.
- CRC_CHECK_EN undefined: no crc_match port, no RESIDUE compare logic; all other behaviour identical.

## Test plan
- Defaults, ASCII "123456789" as 9 beats, last on '9', out_ready = 1 -> crc_out = 32'hFC891918, frame_beats = 9, out_valid one cycle after last beat.
- XOR_OUT = 0 (CRC-32/MPEG-2), same stream -> crc_out = 32'h0376E6E7.
- REFLECT_IN = REFLECT_OUT = 1, POLY 32'h04C11DB7 (CRC-32/ISO-HDLC), same stream -> crc_out = 32'hCBF43926.
- Two back-to-back "123456789" frames with out_ready low 5 cycles after first -> in_ready low during stall, first result held at 32'hFC891918, second frame yields same value, no beat lost.
- abort after 4 beats, then full "123456789" frame -> only 32'hFC891918, frame_beats = 9; rst mid-frame -> all outputs 0, next frame correct.
- CRC_CHECK_EN: "123456789" followed by bytes FC 89 19 18 -> crc_match = 1; corrupt one bit -> crc_match = 0.
